clk_supervisor: RTL and testbench

Parametrised clock-subsystem supervisor for Series-7 designs. It runs on the free-running buffered input clock and drives the MMCM reset. It qualifies the (asynchronous) MMCM lock indication and releases NUM_OUT domain resets in a staggered order once lock is stable. On timeout or lock loss it re-arms the MMCM, retries a bounded number of times, then latches a failure.

---
 rtl/clk_supervisor_pkg.sv | 25 ++
 rtl/clk_supervisor_sync_bit.sv | 20 ++
 rtl/clk_supervisor.sv | 149 ++++++++++++++
 tb/tb_clk_supervisor.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/clk_supervisor_pkg.sv
// Shared types and helpers for the clock-subsystem supervisor.
package clk_supervisor_pkg;

   typedef enum logic [2:0] {
      PLL_RST,
      WAIT_LOCK,
      STABLE,
      RELEASE,
      RUN,
      FAIL
   } state_t;

   localparam int LOSS_CNT_W = 8;

   // Width able to hold the largest of the supplied counts (minimum one bit).
   function automatic int cnt_width(input int a, input int b, input int c, input int d);
      int m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      if (d > m) m = d;
      return (m > 1) ? $clog2(m) : 1;
   endfunction

endpackage

// File: rtl/clk_supervisor_sync_bit.sv
// sync_bit: STAGES-deep single-bit synchroniser, synchronous active-high reset to 0.
module sync_bit #(
   parameter int STAGES = 2
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic d_i,
   output logic q_o
);

   (* ASYNC_REG = "TRUE" *) logic [STAGES-1:0] sync_p;

   always_ff @(posedge clk_i) begin
      if (rst_i) sync_p <= '0;
      else       sync_p <= {sync_p[STAGES-2:0], d_i};
   end

   assign q_o = sync_p[STAGES-1];

endmodule

// File: rtl/clk_supervisor.sv
// MMCM lock supervisor with staggered domain reset release and bounded retry.
// Optional lock-loss counter is built when CLK_SUP_LOSS_CNT_EN is defined.
module clk_supervisor
   import clk_supervisor_pkg::*;
#(
   parameter int NUM_OUT      = 2,
   parameter int RST_PULSE    = 16,
   parameter int LOCK_TIMEOUT = 65536,
   parameter int LOCK_STABLE  = 1024,
   parameter int STAGGER      = 8,
   parameter int MAX_RETRY    = 4,
   parameter int SYNC_STAGES  = 2
) (
   input  logic                           clk_i,
   input  logic                           rst_i,
   input  logic                           locked_i,
   input  logic                           clear_i,
   output logic                           mmcm_rst_o,
   output logic [NUM_OUT-1:0]             rst_o,
   output logic                           ready_o,
   output logic                           fail_o,
   output logic [$clog2(MAX_RETRY+1)-1:0] retry_cnt_o
`ifdef CLK_SUP_LOSS_CNT_EN
   ,
   output logic [LOSS_CNT_W-1:0]          lock_loss_cnt_o
`endif
);

   localparam int CNT_W   = cnt_width(RST_PULSE, LOCK_TIMEOUT, LOCK_STABLE, (NUM_OUT-1)*STAGGER+1);
   localparam int RETRY_W = $clog2(MAX_RETRY+1);

   typedef logic [CNT_W-1:0] cnt_t;

   localparam cnt_t RST_LAST = cnt_t'(RST_PULSE-1);
   localparam cnt_t TMO_LAST = cnt_t'(LOCK_TIMEOUT-1);
   localparam cnt_t STB_LAST = cnt_t'(LOCK_STABLE-1);
   localparam cnt_t REL_LAST = cnt_t'((NUM_OUT-1)*STAGGER);
   localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRY);

   logic                 lock_s;
   state_t               state_q, state_d;
   cnt_t                 cnt_q, cnt_d;
   logic [RETRY_W-1:0]   retry_d, retry_inc;
   logic                 mmcm_d, ready_d, fail_d;
   logic [NUM_OUT-1:0]   rst_d;

   sync_bit #(
      .STAGES (SYNC_STAGES)
   ) u_lock_sync (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .d_i   (locked_i),
      .q_o   (lock_s)
   );

   assign retry_inc = (retry_cnt_o == RETRY_MAX) ? RETRY_MAX : retry_cnt_o + RETRY_W'(1);

   always_comb begin
      state_d = state_q;
      retry_d = retry_cnt_o;
      unique case (state_q)
         PLL_RST: begin
            if (cnt_q == RST_LAST) state_d = WAIT_LOCK;
         end
         WAIT_LOCK: begin
            if (lock_s) begin
               state_d = STABLE;
            end else if (cnt_q == TMO_LAST) begin
               retry_d = retry_inc;
               state_d = (retry_inc == RETRY_MAX) ? FAIL : PLL_RST;
            end
         end
         STABLE, RELEASE: begin
            if (!lock_s) begin
               retry_d = retry_inc;
               state_d = (retry_inc == RETRY_MAX) ? FAIL : PLL_RST;
            end else if (state_q == STABLE && cnt_q == STB_LAST) begin
               state_d = RELEASE;
            end else if (state_q == RELEASE && cnt_q == REL_LAST) begin
               state_d = RUN;
            end
         end
         RUN: begin
            if (!lock_s) state_d = PLL_RST;
         end
         FAIL: begin
            if (clear_i) begin
               state_d = PLL_RST;
               retry_d = '0;
            end
         end
         default: state_d = PLL_RST;
      endcase
      // A successful run, or a loss from RUN, starts a fresh retry budget.
      if (state_d == RUN || state_q == RUN) retry_d = '0;
   end

   always_comb begin
      cnt_d = cnt_q;
      if (state_d != state_q)                   cnt_d = '0;
      else if (state_q != RUN && state_q != FAIL) cnt_d = cnt_q + cnt_t'(1);

      mmcm_d  = (state_d == PLL_RST) || (state_d == FAIL);
      ready_d = (state_d == RUN);
      fail_d  = (state_d == FAIL);

      rst_d = '1;
      if (state_d == RUN) begin
         rst_d = '0;
      end else if (state_d == RELEASE) begin
         for (int k = 0; k < NUM_OUT; k++) rst_d[k] = (int'(cnt_d) < k*STAGGER);
      end
   end

   // Outputs are registered from the next-state decode so they line up with state_q.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q     <= PLL_RST;
         cnt_q       <= '0;
         mmcm_rst_o  <= 1'b1;
         rst_o       <= '1;
         ready_o     <= 1'b0;
         fail_o      <= 1'b0;
         retry_cnt_o <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         mmcm_rst_o  <= mmcm_d;
         rst_o       <= rst_d;
         ready_o     <= ready_d;
         fail_o      <= fail_d;
         retry_cnt_o <= retry_d;
      end
   end

`ifdef CLK_SUP_LOSS_CNT_EN
   logic loss_inc;

   assign loss_inc = (state_q == RUN) && (state_d == PLL_RST);

   always_ff @(posedge clk_i) begin
      if (rst_i)
         lock_loss_cnt_o <= '0;
      else if (loss_inc && lock_loss_cnt_o != '1)
         lock_loss_cnt_o <= lock_loss_cnt_o + LOSS_CNT_W'(1);
   end
`endif

endmodule

// File: tb/tb_clk_supervisor.sv
// Scenario bench for clk_supervisor (small parameter set, optional loss counter).
module tb_clk_supervisor;

   logic       clk_i = 1'b0;
   logic       rst_i = 1'b1;
   logic       locked_i = 1'b0;
   logic       clear_i = 1'b0;
   logic       mmcm_rst_o;
   logic [2:0] rst_o;
   logic       ready_o;
   logic       fail_o;
   logic [1:0] retry_cnt_o;
`ifdef CLK_SUP_LOSS_CNT_EN
   logic [7:0] lock_loss_cnt_o;
`endif

   int n_checks = 0;
   int n_fail   = 0;
   int         exp_len_q[$];
   logic [2:0] exp_rst_q[$];

   always #5 clk_i = ~clk_i;

   clk_supervisor #(
      .NUM_OUT      (3),
      .RST_PULSE    (4),
      .LOCK_TIMEOUT (32),
      .LOCK_STABLE  (8),
      .STAGGER      (2),
      .MAX_RETRY    (2),
      .SYNC_STAGES  (2)
   ) dut (
      .clk_i           (clk_i),
      .rst_i           (rst_i),
      .locked_i        (locked_i),
      .clear_i         (clear_i),
      .mmcm_rst_o      (mmcm_rst_o),
      .rst_o           (rst_o),
      .ready_o         (ready_o),
      .fail_o          (fail_o),
      .retry_cnt_o     (retry_cnt_o)
`ifdef CLK_SUP_LOSS_CNT_EN
      ,
      .lock_loss_cnt_o (lock_loss_cnt_o)
`endif
   );

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic do_reset();
      rst_i = 1'b1;
      tick();
      tick();
      rst_i = 1'b0;
   endtask

   task automatic count_high(output int n);
      n = 0;
      while (mmcm_rst_o === 1'b1 && n < 200) begin
         n++;
         tick();
      end
   endtask

   task automatic count_low(output int n);
      n = 0;
      while (mmcm_rst_o === 1'b0 && n < 200) begin
         n++;
         tick();
      end
   endtask

   task automatic test_reset();
      rst_i = 1'b1; locked_i = 1'b0; clear_i = 1'b0;
      repeat (3) tick();
      n_checks++; if (mmcm_rst_o !== 1'b1) begin n_fail++; $display("FAIL reset_mmcm: got %b want 1", mmcm_rst_o); end
      n_checks++; if (rst_o !== 3'b111) begin n_fail++; $display("FAIL reset_rst: got %b want 111", rst_o); end
      n_checks++; if (ready_o !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b want 0", ready_o); end
      n_checks++; if (fail_o !== 1'b0) begin n_fail++; $display("FAIL reset_fail: got %b want 0", fail_o); end
      n_checks++; if (retry_cnt_o !== 2'd0) begin n_fail++; $display("FAIL reset_retry: got %0d want 0", retry_cnt_o); end
`ifdef CLK_SUP_LOSS_CNT_EN
      n_checks++; if (lock_loss_cnt_o !== 8'd0) begin n_fail++; $display("FAIL reset_loss: got %0d want 0", lock_loss_cnt_o); end
`endif
      rst_i = 1'b0;
   endtask

   task automatic test_nominal();
      int n, lat, gap;
      logic [2:0] prev, exp;
      count_high(n);
      n_checks++; if (n !== 4) begin n_fail++; $display("FAIL nom_pulse: got %0d want 4", n); end
      repeat (4) tick();
      locked_i = 1'b1;
      exp_rst_q.push_back(3'b110);
      exp_rst_q.push_back(3'b100);
      exp_rst_q.push_back(3'b000);
      prev = rst_o; lat = 0; gap = 0;
      while (exp_rst_q.size() > 0 && lat < 100) begin
         tick();
         lat++; gap++;
         if (rst_o !== prev) begin
            exp = exp_rst_q.pop_front();
            n_checks++; if (rst_o !== exp) begin n_fail++; $display("FAIL nom_seq: got %b want %b", rst_o, exp); end
            if (exp == 3'b110) begin
               n_checks++; if (lat !== 11) begin n_fail++; $display("FAIL nom_lock_to_rel: got %0d want 11", lat); end
            end else begin
               n_checks++; if (gap !== 2) begin n_fail++; $display("FAIL nom_stagger: got %0d want 2", gap); end
            end
            gap = 0; prev = rst_o;
         end
      end
      n_checks++; if (exp_rst_q.size() !== 0) begin n_fail++; $display("FAIL nom_timeout: got %0d pending want 0", exp_rst_q.size()); end
      exp_rst_q.delete();
      n_checks++; if (ready_o !== 1'b0) begin n_fail++; $display("FAIL nom_ready_early: got %b want 0", ready_o); end
      tick();
      n_checks++; if (ready_o !== 1'b1) begin n_fail++; $display("FAIL nom_ready: got %b want 1", ready_o); end
      n_checks++; if (mmcm_rst_o !== 1'b0) begin n_fail++; $display("FAIL nom_mmcm: got %b want 0", mmcm_rst_o); end
      n_checks++; if (retry_cnt_o !== 2'd0) begin n_fail++; $display("FAIL nom_retry: got %0d want 0", retry_cnt_o); end
   endtask

   task automatic test_loss_run();
      int n;
      locked_i = 1'b0;
      tick();
      locked_i = 1'b1;
      n = 1;
      while (!(rst_o === 3'b111 && ready_o === 1'b0) && n < 10) begin
         tick();
         n++;
      end
      n_checks++; if (n !== 3) begin n_fail++; $display("FAIL loss_latency: got %0d want 3", n); end
      n_checks++; if (mmcm_rst_o !== 1'b1) begin n_fail++; $display("FAIL loss_mmcm: got %b want 1", mmcm_rst_o); end
      n_checks++; if (retry_cnt_o !== 2'd0) begin n_fail++; $display("FAIL loss_retry: got %0d want 0", retry_cnt_o); end
`ifdef CLK_SUP_LOSS_CNT_EN
      n_checks++; if (lock_loss_cnt_o !== 8'd1) begin n_fail++; $display("FAIL loss_cnt: got %0d want 1", lock_loss_cnt_o); end
`endif
      n = 0;
      while (ready_o !== 1'b1 && n < 100) begin
         tick();
         n++;
      end
      n_checks++; if (ready_o !== 1'b1) begin n_fail++; $display("FAIL loss_relock: got %b want 1", ready_o); end
      n_checks++; if (rst_o !== 3'b000) begin n_fail++; $display("FAIL loss_relock_rst: got %b want 000", rst_o); end
      n_checks++; if (retry_cnt_o !== 2'd0) begin n_fail++; $display("FAIL loss_relock_retry: got %0d want 0", retry_cnt_o); end
   endtask

   task automatic test_glitch();
      int n;
      bit early;
      locked_i = 1'b0;
      do_reset();
      count_high(n);
      n_checks++; if (n !== 4) begin n_fail++; $display("FAIL glitch_pulse0: got %0d want 4", n); end
      locked_i = 1'b1;
      repeat (5) tick();
      locked_i = 1'b0;
      tick();
      locked_i = 1'b1;
      early = 1'b0; n = 0;
      while (mmcm_rst_o !== 1'b1 && n < 40) begin
         tick();
         n++;
         if (rst_o !== 3'b111) early = 1'b1;
      end
      n_checks++; if (mmcm_rst_o !== 1'b1) begin n_fail++; $display("FAIL glitch_rearm: got %b want 1", mmcm_rst_o); end
      n_checks++; if (early !== 1'b0) begin n_fail++; $display("FAIL glitch_early_release: got %b want 0", early); end
      n_checks++; if (retry_cnt_o !== 2'd1) begin n_fail++; $display("FAIL glitch_retry: got %0d want 1", retry_cnt_o); end
      count_high(n);
      n_checks++; if (n !== 4) begin n_fail++; $display("FAIL glitch_pulse1: got %0d want 4", n); end
   endtask

   task automatic test_reset_mid_release();
      int n;
      n = 0;
      while (rst_o !== 3'b100 && n < 60) begin
         tick();
         n++;
      end
      n_checks++; if (rst_o !== 3'b100) begin n_fail++; $display("FAIL mid_reach: got %b want 100", rst_o); end
      rst_i = 1'b1;
      tick();
      n_checks++; if (rst_o !== 3'b111) begin n_fail++; $display("FAIL mid_rst: got %b want 111", rst_o); end
      n_checks++; if (mmcm_rst_o !== 1'b1) begin n_fail++; $display("FAIL mid_mmcm: got %b want 1", mmcm_rst_o); end
      n_checks++; if (retry_cnt_o !== 2'd0) begin n_fail++; $display("FAIL mid_retry: got %0d want 0", retry_cnt_o); end
      n_checks++; if (ready_o !== 1'b0) begin n_fail++; $display("FAIL mid_ready: got %b want 0", ready_o); end
`ifdef CLK_SUP_LOSS_CNT_EN
      n_checks++; if (lock_loss_cnt_o !== 8'd0) begin n_fail++; $display("FAIL mid_loss: got %0d want 0", lock_loss_cnt_o); end
`endif
      rst_i = 1'b0;
   endtask

   task automatic test_timeout();
      int n, e;
      locked_i = 1'b0;
      do_reset();
      exp_len_q.push_back(4);
      exp_len_q.push_back(32);
      exp_len_q.push_back(4);
      exp_len_q.push_back(32);
      for (int i = 0; i < 2; i++) begin
         count_high(n);
         e = exp_len_q.pop_front();
         n_checks++; if (n !== e) begin n_fail++; $display("FAIL tmo_pulse%0d: got %0d want %0d", i, n, e); end
         count_low(n);
         e = exp_len_q.pop_front();
         n_checks++; if (n !== e) begin n_fail++; $display("FAIL tmo_wait%0d: got %0d want %0d", i, n, e); end
         n_checks++; if (retry_cnt_o !== 2'(i + 1)) begin n_fail++; $display("FAIL tmo_retry%0d: got %0d want %0d", i, retry_cnt_o, i + 1); end
      end
      n_checks++; if (fail_o !== 1'b1) begin n_fail++; $display("FAIL tmo_fail: got %b want 1", fail_o); end
      repeat (10) tick();
      n_checks++; if (mmcm_rst_o !== 1'b1) begin n_fail++; $display("FAIL tmo_stuck: got %b want 1", mmcm_rst_o); end
      n_checks++; if (fail_o !== 1'b1) begin n_fail++; $display("FAIL tmo_fail_hold: got %b want 1", fail_o); end
      n_checks++; if (rst_o !== 3'b111) begin n_fail++; $display("FAIL tmo_rst: got %b want 111", rst_o); end
      clear_i = 1'b1;
      tick();
      clear_i = 1'b0;
      n_checks++; if (fail_o !== 1'b0) begin n_fail++; $display("FAIL clr_fail: got %b want 0", fail_o); end
      n_checks++; if (retry_cnt_o !== 2'd0) begin n_fail++; $display("FAIL clr_retry: got %0d want 0", retry_cnt_o); end
      count_high(n);
      n_checks++; if (n !== 4) begin n_fail++; $display("FAIL clr_pulse: got %0d want 4", n); end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete within time limit");
      $fatal(1, "watchdog expired");
   end

   initial begin
      test_reset();
      test_nominal();
      test_loss_run();
      test_glitch();
      test_reset_mid_release();
      test_timeout();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
